array_divider: RTL
==================

Name: array_divider

Overview:
- Pipelined restoring array divider. Computes Q = N / D and R = N % D for a 2*WIDTH-bit unsigned dividend and a WIDTH-bit unsigned divisor.
- One pipeline stage per quotient bit. Accepts one operation per cycle with fixed latency.
- Inverse companion to the array multiplier in the microbench suite. A divider bench can feed multiplier products back through this block and check that the original operands are recovered.

Parameters:
- WIDTH, 8, divisor/remainder width; dividend and quotient are 2*WIDTH bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- N  input  2*WIDTH  dividend, sampled when start=1
- D  input  WIDTH  divisor, sampled when start=1
- start  input  1  launch an operation this cycle
- Q  output  2*WIDTH  quotient, valid when done=1
- R  output  WIDTH  remainder, valid when done=1
- div_by_zero  output  1  D was 0 for the operation completing now; qualified by done
- done  output  1  result for the operation launched 2*WIDTH cycles earlier is on Q/R

Behaviour:
- Reset: reset=1 at a rising edge clears every stage register, including valid bits, partial remainders, quotient and operand copies.
  - Outputs after that edge: Q=0, R=0, div_by_zero=0, done=0.
  - reset has priority over start in the same cycle. The start is dropped.
- Latency: start=1 sampled at edge t makes done=1 with matching Q/R/div_by_zero on the cycle following edge t+2*WIDTH-1, i.e. 2*WIDTH edges later.
  - Throughput is 1 op/cycle. Back-to-back starts give back-to-back dones in order.
  - done=0 in every cycle whose corresponding launch cycle had start=0.
- Pipeline: stages s = 0..2*WIDTH-1.
  - Each stage carries: valid bit, D copy, remaining dividend bits, partial remainder (WIDTH+1 bits), quotient bits so far, zero flag.
  - Stage s resolves quotient bit 2*WIDTH-1-s (MSB first).
  - Trial value: t = {r[WIDTH-1:0], next dividend bit}.
  - If t >= {1'b0, D}: r_next = t - D and the q bit is 1. Otherwise r_next = t and the q bit is 0.
  - Stage 0 starts from r = 0 using N directly from the inputs.
- Width rule: the partial remainder is always < 2*D before subtraction, so WIDTH+1 bits cannot overflow. The final R is the low WIDTH bits, which is always < D when D != 0.
- Valid handling: the valid bit shifts with the data. Stages with valid=0 keep advancing; their contents are don't-care, but done must stay 0 for them.
- Divide by zero (D=0), decided output values:
  - Q = all ones.
  - R = N[WIDTH-1:0].
  - div_by_zero = 1.
  - The zero flag is captured at stage 0 and overrides the arithmetic at the output stage.
  - div_by_zero = 0 whenever done = 0.
- Outputs are registered directly from the final stage; there is no combinational path from the inputs.
- Mid-operation reset: all in-flight operations are discarded. After reset deasserts, done stays 0 until 2*WIDTH cycles after the first new start.
- Edge cases:
  - N=0 gives Q=0, R=0.
  - D=1 gives Q=N, R=0.
  - N < D gives Q=0, R=N[WIDTH-1:0].

Test Plan (WIDTH=4, latency 8):
- Single op: N=200 (0xC8), D=13, start for 1 cycle -> exactly 8 cycles later done=1, Q=15, R=5, div_by_zero=0; done=0 on all other cycles.
- Boundary ops, back-to-back on consecutive cycles:
  - N=255, D=1 -> Q=255, R=0.
  - N=0, D=7 -> Q=0, R=0.
  - N=6, D=15 -> Q=0, R=6.
  - N=255, D=15 -> Q=17, R=0.
  - Results appear on 4 consecutive done cycles, in order.
- Divide by zero: N=0xA5, D=0 -> Q=0xFF, R=0x5, div_by_zero=1. Next op N=100, D=10 -> Q=10, R=0, div_by_zero=0.
- Sweep: start=1 every cycle for all 256x15 pairs with D=1..15. Each result is checked against a golden model with a 8-cycle offset, and N == Q*D + R with R < D.
- Reset mid-flight: launch 4 ops, assert reset for 1 cycle 3 cycles later, also with start=1 in that cycle -> Q=0, R=0, done=0 from the next cycle; no done for the dropped/flushed ops. A new op (N=9, D=2) after reset gives Q=4, R=1 eight cycles later.
- Sparse starts: start pattern 1,0,0,1,0 -> done pattern 1,0,0,1,0 offset by 8 cycles.

Source files
------------

// File: rtl/array_divider.sv
// Pipelined restoring array divider: one stage per quotient bit, MSB first.
// Q = N / D and R = N % D with a fixed latency of 2*WIDTH cycles and one new operation accepted per cycle.
module array_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   N,
  input  logic [WIDTH-1:0]     D,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]     R,
  output logic                 div_by_zero,
  output logic                 done
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned IW = $clog2(W2);

  logic             valid_q [W2];
  logic             valid_d [W2];
  logic [WIDTH-1:0] dv_q    [W2];
  logic [WIDTH-1:0] dv_d    [W2];
  logic [W2-1:0]    n_q     [W2];
  logic [W2-1:0]    n_d     [W2];
  logic [RW-1:0]    r_q     [W2];
  logic [RW-1:0]    r_d     [W2];
  logic [W2-1:0]    quo_q   [W2];
  logic [W2-1:0]    quo_d   [W2];
  logic             zero_q  [W2];
  logic             zero_d  [W2];

  // Stage inputs: stage 0 is fed straight from the ports, later stages from the previous stage.
  logic             in_valid [W2];
  logic [WIDTH-1:0] in_dv    [W2];
  logic [W2-1:0]    in_n     [W2];
  logic [RW-1:0]    in_r     [W2];
  logic [W2-1:0]    in_quo   [W2];
  logic             in_zero  [W2];
  logic [RW-1:0]    trial;

  always_comb begin
    trial       = '0;
    in_valid[0] = start;
    in_dv[0]    = D;
    in_n[0]     = N;
    in_r[0]     = '0;
    in_quo[0]   = '0;
    in_zero[0]  = (D == '0);
    for (int s = 1; s < W2; s++) begin
      in_valid[s] = valid_q[s-1];
      in_dv[s]    = dv_q[s-1];
      in_n[s]     = n_q[s-1];
      in_r[s]     = r_q[s-1];
      in_quo[s]   = quo_q[s-1];
      in_zero[s]  = zero_q[s-1];
    end
    // Each stage shifts in the next dividend bit and subtracts D when it fits.
    for (int s = 0; s < W2; s++) begin
      valid_d[s] = in_valid[s];
      dv_d[s]    = in_dv[s];
      n_d[s]     = in_n[s];
      zero_d[s]  = in_zero[s];
      quo_d[s]   = in_quo[s];
      trial      = {in_r[s][WIDTH-1:0], in_n[s][IW'(W2 - 1 - s)]};
      if (trial >= {1'b0, in_dv[s]}) begin
        r_d[s]                       = trial - {1'b0, in_dv[s]};
        quo_d[s][IW'(W2 - 1 - s)]    = 1'b1;
      end else begin
        r_d[s] = trial;
      end
    end
    // Output stage: divide-by-zero forces the defined result and the flag only counts for a live op.
    if (in_zero[W2-1]) begin
      quo_d[W2-1] = '1;
      r_d[W2-1]   = {1'b0, in_n[W2-1][WIDTH-1:0]};
    end
    zero_d[W2-1] = in_zero[W2-1] & in_valid[W2-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < W2; s++) begin
        valid_q[s] <= 1'b0;
        dv_q[s]    <= '0;
        n_q[s]     <= '0;
        r_q[s]     <= '0;
        quo_q[s]   <= '0;
        zero_q[s]  <= 1'b0;
      end
    end else begin
      for (int s = 0; s < W2; s++) begin
        valid_q[s] <= valid_d[s];
        dv_q[s]    <= dv_d[s];
        n_q[s]     <= n_d[s];
        r_q[s]     <= r_d[s];
        quo_q[s]   <= quo_d[s];
        zero_q[s]  <= zero_d[s];
      end
    end
  end

  assign Q           = quo_q[W2-1];
  assign R           = r_q[W2-1][WIDTH-1:0];
  assign div_by_zero = zero_q[W2-1];
  assign done        = valid_q[W2-1];

endmodule
